// File: rtl/alu_if.sv
// Execute-stage to ALU bundle: operands and op select in, combinational result and flags out.
// The master is the execute stage; the ALU is the slave.
interface alu_if;
  logic [2:0]  opcode;
  logic [3:0]  alu_op;
  logic [15:0] lhs;
  logic [15:0] rhs;
  logic        bubble_in;
  logic [15:0] alu_rslt;
  logic [3:0]  flags;

  modport master (
    output opcode, alu_op, lhs, rhs, bubble_in,
    input  alu_rslt, flags
  );

  modport slave (
    input  opcode, alu_op, lhs, rhs, bubble_in,
    output alu_rslt, flags
  );
endinterface

// File: rtl/alu.sv
// 16-bit execute-stage ALU: alu_rslt is combinational (0 cycles), flags {V,N,Z,C} land 1 cycle later.
// No backpressure: every cycle is accepted and bubbles simply leave the flags untouched.
module alu (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [3:0]  flags_q, flags_d;
  logic [15:0] rslt;
  logic        c_out, v_out;
  logic        is_alu;

  logic        sub_sel;
  logic        arith_cin;
  logic [15:0] op_b;
  logic [16:0] sum;
  logic        arith_v;
  logic [3:0]  amt;
  logic [16:0] shl_w, shr_w, sar_w;
  logic [15:0] rol_w, ror_w;

  assign is_alu = (bus.opcode[2:1] == 2'b00);
  assign amt    = bus.rhs[3:0];

  // Subtraction is lhs + ~rhs + cin; ADDC/SUBB take the carry held from the previous flag update.
  assign sub_sel   = (bus.alu_op == 4'd2) || (bus.alu_op == 4'd3);
  assign op_b      = sub_sel ? ~bus.rhs : bus.rhs;
  assign arith_cin = bus.alu_op[0] ? flags_q[0] : bus.alu_op[1];
  assign sum       = {1'b0, bus.lhs} + {1'b0, op_b} + {16'b0, arith_cin};
  assign arith_v   = (bus.lhs[15] == op_b[15]) && (sum[15] != bus.lhs[15]);

  // One extra bit beside each shift catches the last bit shifted out; it is zero for amount 0.
  assign shl_w = {1'b0, bus.lhs} << amt;
  assign shr_w = {bus.lhs, 1'b0} >> amt;
  assign sar_w = $signed({bus.lhs, 1'b0}) >>> amt;
  assign rol_w = (bus.lhs << amt) | (bus.lhs >> (5'd16 - {1'b0, amt}));
  assign ror_w = (bus.lhs >> amt) | (bus.lhs << (5'd16 - {1'b0, amt}));

  always_comb begin
    rslt  = bus.lhs + bus.rhs;
    c_out = 1'b0;
    v_out = 1'b0;
    if (is_alu) begin
      case (bus.alu_op)
        4'd0, 4'd1, 4'd2, 4'd3: begin
          rslt  = sum[15:0];
          c_out = sum[16];
          v_out = arith_v;
        end
        4'd4:  rslt = bus.lhs & bus.rhs;
        4'd5:  rslt = bus.lhs | bus.rhs;
        4'd6:  rslt = bus.lhs ^ bus.rhs;
        4'd7:  rslt = ~bus.rhs;
        4'd8: begin
          rslt  = shl_w[15:0];
          c_out = shl_w[16];
        end
        4'd9: begin
          rslt  = shr_w[16:1];
          c_out = shr_w[0];
        end
        4'd10: begin
          rslt  = sar_w[16:1];
          c_out = sar_w[0];
        end
        4'd11: begin
          rslt  = rol_w;
          c_out = (amt != 4'd0) && rol_w[0];
        end
        4'd12: begin
          rslt  = ror_w;
          c_out = (amt != 4'd0) && ror_w[15];
        end
        4'd13: rslt = bus.lhs * bus.rhs;
        4'd14: rslt = bus.rhs;
        default: rslt = bus.lhs;
      endcase
    end else if (bus.opcode == 3'b011) begin
      rslt = bus.lhs;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (!bus.bubble_in && is_alu) begin
      flags_d = {v_out, rslt[15], (rslt == 16'h0000), c_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.alu_rslt = rslt;
  assign bus.flags    = flags_q;

endmodule

// File: tb/tb_alu.sv
// Randomized and directed check of alu against a plain-arithmetic reference model.
module tb_alu;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] model_flags = 4'b0000;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // Reference: integer arithmetic, signed range test for V, explicit bit picks for carries.
  function automatic void model(input logic [2:0] op, input logic [3:0] aop,
                                input logic [15:0] l, input logic [15:0] r, input logic cin,
                                output logic [15:0] res, output logic [3:0] f);
    longint ul, ur, sl, sr, u, s;
    int     amt;
    logic   c, v;
    logic [15:0] t;
    ul = l; ur = r; sl = $signed(l); sr = $signed(r);
    amt = r[3:0];
    c = 1'b0; v = 1'b0;
    u = ul + ur;
    t = u[15:0];
    res = t;
    if (op == 3'b011) res = l;
    if (op[2:1] == 2'b00) begin
      case (aop)
        4'd0, 4'd1, 4'd2, 4'd3: begin
          if (aop < 2) begin
            u = ul + ur + ((aop == 1) ? longint'(cin) : 0);
            s = sl + sr + ((aop == 1) ? longint'(cin) : 0);
          end else begin
            u = ul + (65535 - ur) + ((aop == 2) ? 1 : longint'(cin));
            s = sl - sr - 1 + ((aop == 2) ? 1 : longint'(cin));
          end
          t = u[15:0]; res = t;
          c = (u > 65535);
          v = (s > 32767) || (s < -32768);
        end
        4'd4: res = l & r;
        4'd5: res = l | r;
        4'd6: res = l ^ r;
        4'd7: res = ~r;
        4'd8: begin
          u = ul * (longint'(1) << amt);
          t = u[15:0]; res = t;
          c = u[16];
        end
        4'd9: begin
          u = ul / (longint'(1) << amt);
          t = u[15:0]; res = t;
          if (amt != 0) begin u = ul >> (amt - 1); c = u[0]; end
        end
        4'd10: begin
          s = sl >>> amt;
          t = s[15:0]; res = t;
          if (amt != 0) begin s = sl >>> (amt - 1); c = s[0]; end
        end
        4'd11: begin
          u = (ul * (longint'(1) << amt)) + (ul >> (16 - amt));
          t = u[15:0]; res = t;
          c = (amt != 0) && t[0];
        end
        4'd12: begin
          u = (ul >> amt) + (ul * (longint'(1) << (16 - amt)));
          t = u[15:0]; res = t;
          c = (amt != 0) && t[15];
        end
        4'd13: begin
          u = ul * ur;
          t = u[15:0]; res = t;
        end
        4'd14: res = r;
        default: res = l;
      endcase
    end
    f = {v, res[15], (res == 16'h0000), c};
  endfunction

  task automatic step(input logic [2:0] op, input logic [3:0] aop,
                      input logic [15:0] l, input logic [15:0] r,
                      input logic bub, input logic rs,
                      input bit directed, input logic [15:0] xr, input logic [3:0] xf,
                      input string tag);
    logic [15:0] mr;
    logic [3:0]  mf;
    @(negedge clk);
    bus.opcode = op; bus.alu_op = aop; bus.lhs = l; bus.rhs = r;
    bus.bubble_in = bub; rst = rs;
    #1;
    model(op, aop, l, r, model_flags[0], mr, mf);
    chk({tag, ".rslt"}, bus.alu_rslt, directed ? xr : mr);
    @(posedge clk);
    if (rs) model_flags = 4'b0000;
    else if (!bub && op[2:1] == 2'b00) model_flags = mf;
    #1;
    chk({tag, ".flags"}, {12'h000, bus.flags}, {12'h000, directed ? xf : model_flags});
  endtask

  initial begin
    logic [15:0] l, r;
    rst = 1'b1;
    bus.opcode = 3'b000; bus.alu_op = 4'd0; bus.lhs = 16'h0; bus.rhs = 16'h0; bus.bubble_in = 1'b1;

    step(3'b011, 4'd0, 16'h1111, 16'h0,    1, 1, 1, 16'h1111, 4'b0000, "reset");
    step(3'b000, 4'd0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000, 4'b0000, "rst_add0");
    step(3'b000, 4'd0, 16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 4'b1100, "add_ovf");
    step(3'b000, 4'd2, 16'h0005, 16'h0005, 0, 0, 1, 16'h0000, 4'b0011, "sub_eq");
    step(3'b000, 4'd2, 16'h0003, 16'h0005, 0, 0, 1, 16'hFFFE, 4'b0100, "sub_lt");
    step(3'b001, 4'd2, 16'h8000, 16'h0001, 0, 0, 1, 16'h7FFF, 4'b1001, "sub_ovf");
    step(3'b000, 4'd0, 16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 4'b0011, "add_carry");
    step(3'b000, 4'd1, 16'h0000, 16'h0000, 0, 0, 1, 16'h0001, 4'b0000, "addc");
    step(3'b000, 4'd8, 16'h8001, 16'h0001, 0, 0, 1, 16'h0002, 4'b0001, "shl1");
    step(3'b000, 4'd10, 16'h8000, 16'h000F, 0, 0, 1, 16'hFFFF, 4'b0100, "sar15");
    step(3'b000, 4'd2, 16'h0005, 16'h0005, 1, 0, 1, 16'h0000, 4'b0100, "bubble");
    step(3'b100, 4'd2, 16'h1000, 16'h0004, 0, 0, 1, 16'h1004, 4'b0100, "store_ea");
    step(3'b011, 4'd5, 16'hABCD, 16'h0000, 0, 0, 1, 16'hABCD, 4'b0100, "imm");
    step(3'b000, 4'd9, 16'h1234, 16'h0010, 0, 0, 1, 16'h1234, 4'b0000, "shr0");

    for (int i = 0; i < 600; i++) begin
      l = (i % 7 == 0) ? 16'h8000 : (i % 11 == 0) ? 16'hFFFF : 16'($urandom);
      r = (i % 5 == 0) ? 16'($urandom_range(0, 16)) : 16'($urandom);
      step(3'($urandom_range(0, 7)), 4'($urandom), l, r,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
           0, 16'h0, 4'h0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
